polyveck_pointwise_seq: RTL and testbench

- Sequential, resource-shared replacement for the fully parallel K-poly pointwise Montgomery product r[i] = a ∘ v[i], i = 0..K-1.
- Streams coefficients from external single-port RAMs (poly a; vector v holding K polys) through one pipelined 32x32 Montgomery multiplier, and writes each result coefficient to result RAM r.
- Sits between the sign/verify top-level FSM and the coefficient RAMs. Trades 6x256 parallel multipliers for one, at K*N+4 cycles per operation.

---
 rtl/polyveck_pointwise_seq.sv | 135 +++++++++++++
 tb/tb_polyveck_pointwise_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyveck_pointwise_seq.sv
// Sequential pointwise Montgomery product r[i][j] = a[j] * v[i][j] * 2^-32 mod Q.
// One shared 3-stage multiplier pipeline streams K*N coefficients from the
// a/v RAMs into the r RAM; one operation takes K*N+4 cycles from start to done.
module polyveck_pointwise_seq #(
    parameter int K    = 6,
    parameter int N    = 256,
    parameter int Q    = 8380417,
    parameter int QINV = 58728449
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   a_rd_en,
    output logic [$clog2(N)-1:0]   a_addr,
    input  logic [31:0]            a_rdata,
    output logic                   v_rd_en,
    output logic [$clog2(N)+2:0]   v_addr,
    input  logic [31:0]            v_rdata,
    output logic                   r_wr_en,
    output logic [$clog2(N)+2:0]   r_addr,
    output logic [31:0]            r_wdata
);

    localparam int JW = $clog2(N);
    localparam int AW = JW + 3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [31:0]        QINV32 = 32'(QINV);
    localparam logic signed [63:0] QS     = 64'(Q);

    logic [1:0]        state;
    logic [2:0]        i;
    logic [JW-1:0]     j;
    logic              issue;

    logic [2:0]        vld;
    logic [AW-1:0]     tag0, tag1, tag2;
    logic signed [63:0] prod;
    logic [31:0]       res;

    logic [31:0]       t_lo;
    logic signed [63:0] t64;
    logic signed [63:0] diff;
    logic [31:0]       res_d;

    assign issue   = (state == ISSUE);

    assign busy    = (state == ISSUE) || (state == DRAIN);
    assign done    = (state == DONE);
    assign a_rd_en = issue;
    assign v_rd_en = issue;
    assign a_addr  = j;
    assign v_addr  = {i, j};
    assign r_wr_en = vld[2];
    assign r_addr  = tag2;
    assign r_wdata = res;

    // Control FSM: walk {i,j} over K*N indices, then wait for the pipeline to empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        i     <= '0;
                        j     <= '0;
                    end
                end
                ISSUE: begin
                    if (j == JW'(N - 1)) begin
                        j <= '0;
                        if (i == 3'(K - 1)) begin
                            i     <= '0;
                            state <= DRAIN;
                        end else begin
                            i <= i + 3'd1;
                        end
                    end else begin
                        j <= j + JW'(1);
                    end
                end
                // Stage-2 still holds the final write in the cycle where stages 0/1 are empty
                DRAIN: begin
                    if (!vld[0] && !vld[1]) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Montgomery reduction of the registered 64-bit product; no truncation before the subtract
    always_comb begin
        t_lo  = prod[31:0] * QINV32;
        t64   = $signed({{32{t_lo[31]}}, t_lo});
        diff  = prod - (t64 * QS);
        res_d = 32'(diff >>> 32);
    end

    // Fixed-latency pipeline: tag/valid shift register alongside product and reduction stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            tag0 <= '0;
            tag1 <= '0;
            tag2 <= '0;
            prod <= '0;
            res  <= '0;
        end else begin
            vld  <= {vld[1:0], issue};
            tag0 <= {i, j};
            tag1 <= tag0;
            tag2 <= tag1;
            prod <= 64'($signed(a_rdata)) * 64'($signed(v_rdata));
            res  <= res_d;
        end
    end

endmodule

// File: tb/tb_polyveck_pointwise_seq.sv
// Directed bench for polyveck_pointwise_seq: RAM models, a negedge bus monitor,
// and per-run checks of timing, address order and Montgomery results.
module tb_polyveck_pointwise_seq;

    localparam int K    = 6;
    localparam int N    = 256;
    localparam int Q    = 8380417;
    localparam int QINV = 58728449;
    localparam int KN   = K * N;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done;
    logic        a_rd_en, v_rd_en, r_wr_en;
    logic [7:0]  a_addr;
    logic [10:0] v_addr, r_addr;
    logic [31:0] a_rdata, v_rdata, r_wdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used to time events relative to start
    always @(posedge clk) cyc <= cyc + 1;

    polyveck_pointwise_seq #(.K(K), .N(N), .Q(Q), .QINV(QINV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
        .v_rd_en(v_rd_en), .v_addr(v_addr), .v_rdata(v_rdata),
        .r_wr_en(r_wr_en), .r_addr(r_addr), .r_wdata(r_wdata)
    );

    logic [31:0] a_mem [N];
    logic [31:0] v_mem [KN];
    logic [31:0] r_mem [KN];
    logic [31:0] a_q, v_q;

    assign a_rdata = a_q;
    assign v_rdata = v_q;

    // Single-port read RAMs: data valid the cycle after the strobe
    always @(posedge clk) begin
        if (a_rd_en) a_q <= a_mem[a_addr];
        if (v_rd_en) v_q <= v_mem[v_addr];
    end

    int n_rd = 0, n_wr = 0, n_busy = 0, n_done = 0;
    int err_addr = 0, err_lag = 0, err_rng = 0, err_strb = 0;
    int rd_first = 0, rd_last = 0, wr_first = 0, wr_last = 0;
    int busy_first = 0, busy_last = 0, done_rel = 0;
    int exp_v = 0, exp_w = 0;
    bit busy_q = 1'b0;
    bit [2:0]    h_vld = '0;
    logic [10:0] h_addr [3];

    // Bus monitor: records timing, address sequence, read-to-write lag, result range; models RAM r
    always @(negedge clk) begin
        int rel;
        rel = cyc - t0 + 1;
        if (!rst_n) begin
            exp_v  = 0;
            exp_w  = 0;
            h_vld  = '0;
            busy_q = 1'b0;
        end else begin
            if (a_rd_en !== v_rd_en) err_strb++;
            if (a_rd_en === 1'b1) begin
                if (exp_v == 0) rd_first = rel;
                rd_last = rel;
                n_rd++;
                if (v_addr !== 11'(exp_v) || a_addr !== 8'(exp_v % N)) err_addr++;
                exp_v = (exp_v == KN - 1) ? 0 : exp_v + 1;
            end
            if (r_wr_en === 1'b1) begin
                if (exp_w == 0) wr_first = rel;
                wr_last = rel;
                n_wr++;
                if (r_addr !== 11'(exp_w)) err_addr++;
                if (!h_vld[2] || h_addr[2] !== r_addr) err_lag++;
                if ($signed(r_wdata) <= -Q || $signed(r_wdata) >= Q) err_rng++;
                r_mem[r_addr] = r_wdata;
                exp_w = (exp_w == KN - 1) ? 0 : exp_w + 1;
            end
            if (busy === 1'b1) begin
                n_busy++;
                if (!busy_q) busy_first = rel;
                busy_last = rel;
            end
            busy_q = (busy === 1'b1);
            if (done === 1'b1) begin
                n_done++;
                done_rel = rel;
            end
            h_vld[2]  = h_vld[1];
            h_addr[2] = h_addr[1];
            h_vld[1]  = h_vld[0];
            h_addr[1] = h_addr[0];
            h_vld[0]  = (v_rd_en === 1'b1);
            h_addr[0] = v_addr;
        end
    end

    int s_rd, s_wr, s_busy, s_done, s_eaddr, s_elag, s_erng, s_estrb;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mont(input int a, input int b);
        longint p;
        int     t;
        longint r;
        p = longint'(a) * longint'(b);
        t = int'(p) * QINV;
        r = (p - longint'(t) * longint'(Q)) >>> 32;
        return int'(r);
    endfunction

    task automatic snap();
        s_rd = n_rd; s_wr = n_wr; s_busy = n_busy; s_done = n_done;
        s_eaddr = err_addr; s_elag = err_lag; s_erng = err_rng; s_estrb = err_strb;
    endtask

    task automatic fill(input int av, input int vv);
        for (int x = 0; x < N; x++)  a_mem[x] = av;
        for (int x = 0; x < KN; x++) v_mem[x] = vv;
    endtask

    task automatic start_op();
        snap();
        start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic finish_op(input int p1, input int p2, input int tail);
        bit got;
        int rel;
        got = 1'b0;
        for (int c = 0; c < KN + 100; c++) begin
            @(posedge clk); #1;
            rel = cyc - t0 + 1;
            start = (rel == p1) || (rel == p2);
            if (n_done != s_done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        repeat (tail) begin @(posedge clk); #1; end
        chk("done_count", n_done - s_done, 1);
        chk("done_cycle", done_rel, KN + 4);
        chk("rd_count", n_rd - s_rd, KN);
        chk("rd_first", rd_first, 1);
        chk("rd_last", rd_last, KN);
        chk("wr_count", n_wr - s_wr, KN);
        chk("wr_first", wr_first, 4);
        chk("wr_last", wr_last, KN + 3);
        chk("busy_first", busy_first, 1);
        chk("busy_last", busy_last, KN + 3);
        chk("busy_count", n_busy - s_busy, KN + 3);
        chk("addr_order", err_addr - s_eaddr, 0);
        chk("rw_lag3", err_lag - s_elag, 0);
        chk("range", err_rng - s_erng, 0);
        chk("strobe_pair", err_strb - s_estrb, 0);
    endtask

    task automatic check_data(input bit use_model, input int cval);
        int e;
        int eb;
        for (int x = 0; x < KN; x++) begin
            e  = use_model ? mont(a_mem[x % N], v_mem[x]) : cval;
            eb = errors;
            chk($sformatf("r[%0d]", x), $signed(r_mem[x]), e);
            if (errors != eb) break;
        end
    endtask

    initial begin
        int sd, sw, sr;
        rst_n = 1'b0;
        start = 1'b0;
        fill(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_a_rd_en", a_rd_en, 0);
        chk("rst_v_rd_en", v_rd_en, 0);
        chk("rst_r_wr_en", r_wr_en, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_v_addr", v_addr, 0);
        chk("rst_r_addr", r_addr, 0);
        chk("rst_r_wdata", r_wdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2^16 * 3*2^16 = 3*2^32 -> exact, result 3
        fill(65536, 196608);
        start_op(); finish_op(0, 0, 2); check_data(1'b0, 3);
        fill(-65536, 196608);
        start_op(); finish_op(0, 0, 2); check_data(1'b0, -3);
        fill(0, 196608);
        start_op(); finish_op(0, 0, 2); check_data(1'b0, 0);
        // 1*1*2^-32 mod Q, hand-reduced: -114592
        fill(1, 1);
        start_op(); finish_op(0, 0, 2); check_data(1'b0, -114592);

        // start pulses mid-run are ignored; only one done
        fill(-65536, 196608);
        start_op(); finish_op(10, 800, 30);
        chk("ign_busy_idle", busy, 0);
        check_data(1'b0, -3);

        // back-to-back: start in the cycle after done
        fill(65536, 196608);
        start_op(); finish_op(0, 0, 0);
        start_op();
        chk("b2b_busy", busy, 1);
        chk("b2b_rd_en", a_rd_en, 1);
        finish_op(0, 0, 2); check_data(1'b0, 3);

        // reset at cycle 700, released at 705
        fill(-65536, 196608);
        start_op();
        repeat (699) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        sd = n_done; sw = n_wr; sr = n_rd;
        chk("mid_rst_a_rd_en", a_rd_en, 0);
        chk("mid_rst_v_rd_en", v_rd_en, 0);
        chk("mid_rst_r_wr_en", r_wr_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        chk("post_rst_busy", busy, 0);
        chk("post_rst_no_done", n_done - sd, 0);
        chk("post_rst_no_wr", n_wr - sw, 0);
        chk("post_rst_no_rd", n_rd - sr, 0);
        fill(65536, 196608);
        start_op(); finish_op(0, 0, 2); check_data(1'b0, 3);

        // random coefficients in (-Q, Q) against the reference reduction
        for (int run = 0; run < 20; run++) begin
            for (int x = 0; x < N; x++)  a_mem[x] = int'($urandom_range(2 * Q - 2, 0)) - (Q - 1);
            for (int x = 0; x < KN; x++) v_mem[x] = int'($urandom_range(2 * Q - 2, 0)) - (Q - 1);
            start_op(); finish_op(0, 0, 2); check_data(1'b1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
